// File: rtl/freq_div_scheduler_pkg.sv
// Shared constants and the tag carried alongside each divide through the divider latency.
package freq_pkg;

  localparam int NUM_CH      = 4;
  localparam int DATA_W      = 32;
  localparam int DIV_LATENCY = 5;
  localparam int CH_W        = 3;  // wide enough for up to 8 channels

  localparam logic [DATA_W-1:0] DIV_ZERO_Q = '1;

  typedef struct packed {
    logic            valid;
    logic [CH_W-1:0] ch;
    logic            div0;
  } tag_t;

endpackage

// File: rtl/freq_div_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer, pointer moves past the winner.
module rr_arbiter
  import freq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_i,
  output logic [N-1:0]    grant_o,
  output logic            grant_any_o,
  output logic [CH_W-1:0] grant_idx_o
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gidx;
  logic [PTR_W-1:0] cand;
  logic             found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    gidx    = '0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % N);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        gidx          = cand;
      end
    end
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
    end
  end

  assign grant_any_o = found;
  assign grant_idx_o = CH_W'(gidx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/freq_div_scheduler.sv
// Shares one pipelined rounding divider among NUM_CH channels; a tag pipe matched to the
// divider latency steers each quotient back to the channel that issued it.
module freq_div_scheduler
  import freq_pkg::*;
#(
  parameter int NUM_CH      = freq_pkg::NUM_CH,
  parameter int DATA_W      = freq_pkg::DATA_W,
  parameter int DIV_LATENCY = freq_pkg::DIV_LATENCY
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH*DATA_W-1:0] req_dividend,
  input  logic [NUM_CH*DATA_W-1:0] req_divisor,
  output logic                     div_start,
  output logic [DATA_W-1:0]        div_dividend,
  output logic [DATA_W-1:0]        div_divisor,
  input  logic [DATA_W-1:0]        div_quotient,
  input  logic                     div_ready,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic [DATA_W-1:0]        rsp_quotient,
  output logic                     rsp_div0,
  output logic                     busy,
  output logic                     err_orphan
);

  logic [NUM_CH-1:0] eligible, grant;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] rsp_valid_q, rsp_valid_d;
  logic              grant_any;
  logic [CH_W-1:0]   grant_ch;
  logic [DATA_W-1:0] sel_dividend, sel_divisor;

  logic              div_start_q, div_start_d;
  logic [DATA_W-1:0] div_dividend_q, div_dividend_d;
  logic [DATA_W-1:0] div_divisor_q, div_divisor_d;
  tag_t              issue_tag_q, issue_tag_d;
  tag_t              tag_q [DIV_LATENCY];
  tag_t              tail;

  logic              rsp_hit;
  logic [DATA_W-1:0] rsp_quotient_q, rsp_quotient_d;
  logic              rsp_div0_q, rsp_div0_d;
  logic              err_orphan_q, err_orphan_d;

  // Gating with rst_n keeps req_ready low while reset is held, like every other output.
  assign eligible = req_valid & ~pending_q & {NUM_CH{rst_n}};

  rr_arbiter #(
    .N (NUM_CH)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (eligible),
    .grant_o     (grant),
    .grant_any_o (grant_any),
    .grant_idx_o (grant_ch)
  );

  assign req_ready = grant;

  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant[c]) begin
        sel_dividend = req_dividend[c*DATA_W +: DATA_W];
        sel_divisor  = req_divisor[c*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    div_start_d    = grant_any;
    div_dividend_d = div_dividend_q;
    div_divisor_d  = div_divisor_q;
    issue_tag_d    = '0;
    if (grant_any) begin
      div_dividend_d    = sel_dividend;
      div_divisor_d     = sel_divisor;
      issue_tag_d.valid = 1'b1;
      issue_tag_d.ch    = grant_ch;
      issue_tag_d.div0  = (sel_divisor == '0);
    end
  end

  // The tail stage lines up with div_ready for the operation issued DIV_LATENCY cycles earlier.
  assign tail    = tag_q[DIV_LATENCY-1];
  assign rsp_hit = div_ready & tail.valid;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rsp
    assign rsp_valid_d[gi] = rsp_hit & (tail.ch == CH_W'(gi));
  end

  always_comb begin
    rsp_quotient_d = rsp_quotient_q;
    rsp_div0_d     = rsp_div0_q;
    if (rsp_hit) begin
      rsp_quotient_d = div_quotient;
      rsp_div0_d     = tail.div0;
    end
    err_orphan_d = err_orphan_q | (div_ready ^ tail.valid);
    pending_d    = (pending_q & ~rsp_valid_q) | grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q      <= '0;
      div_start_q    <= 1'b0;
      div_dividend_q <= '0;
      div_divisor_q  <= '0;
      issue_tag_q    <= '0;
      for (int i = 0; i < DIV_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
      rsp_valid_q    <= '0;
      rsp_quotient_q <= '0;
      rsp_div0_q     <= 1'b0;
      err_orphan_q   <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      div_start_q    <= div_start_d;
      div_dividend_q <= div_dividend_d;
      div_divisor_q  <= div_divisor_d;
      issue_tag_q    <= issue_tag_d;
      tag_q[0]       <= issue_tag_q;
      for (int i = 1; i < DIV_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      rsp_valid_q    <= rsp_valid_d;
      rsp_quotient_q <= rsp_quotient_d;
      rsp_div0_q     <= rsp_div0_d;
      err_orphan_q   <= err_orphan_d;
    end
  end

  assign div_start    = div_start_q;
  assign div_dividend = div_dividend_q;
  assign div_divisor  = div_divisor_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_quotient = rsp_quotient_q;
  assign rsp_div0     = rsp_div0_q;
  assign busy         = |pending_q;
  assign err_orphan   = err_orphan_q;

endmodule
